// File: rtl/rib_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rib_arbiter
// Purpose  : Registered four-master bus arbiter for the RIB interconnect.
//            Fetch (m1) parks on the bus by default. Non-fetch masters
//            (m3 > m2 > m0) take ownership with locking and burst limiting.
//            A one-cycle forced fetch grant bounds instruction-fetch
//            starvation.
// Revision : 1.0  initial release
// ============================================================================
module rib_arbiter #(
    parameter int BURST_LIMIT  = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] gnt_id_o,
    output logic       hold_flag_o,
    output logic       starve_o
);

    localparam logic [1:0] ST_PARK  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    localparam logic [CNT_W-1:0] C_ZERO        = '0;
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_BURST_MAX   = CNT_W'(BURST_LIMIT);
    localparam logic [CNT_W-1:0] C_STARVE_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] C_STARVE_TRIP = CNT_W'(STARVE_LIMIT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       owner;
    logic [1:0]       owner_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic [1:0]       id_nxt;
    logic [2:0]       any_pick;
    logic [2:0]       other_pick;

    // Highest-priority non-fetch requester, optionally excluding one master.
    // Result is {valid, index}.
    function automatic logic [2:0] pick_next(
        input logic [3:0] req,
        input logic [1:0] skip,
        input logic       use_skip
    );
        logic [3:0] cand;
        cand = req & 4'b1101;
        if (use_skip) begin
            cand[skip] = 1'b0;
        end
        if (cand[3]) begin
            pick_next = {1'b1, 2'd3};
        end else if (cand[2]) begin
            pick_next = {1'b1, 2'd2};
        end else if (cand[0]) begin
            pick_next = {1'b1, 2'd0};
        end else begin
            pick_next = 3'b000;
        end
    endfunction

    assign any_pick   = pick_next(req_i, 2'd0, 1'b0);
    assign other_pick = pick_next(req_i, owner, 1'b1);

    // Next ownership decision: starvation, then release, then burst expiry.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        case (state)
            ST_OWN: begin
                if ((starve_cnt == C_STARVE_TRIP) && req_i[1]) begin
                    state_nxt = ST_FORCE;
                    burst_nxt = C_ZERO;
                end else if (!req_i[owner]) begin
                    if (other_pick[2]) begin
                        owner_nxt = other_pick[1:0];
                        burst_nxt = C_ONE;
                    end else begin
                        state_nxt = ST_PARK;
                        burst_nxt = C_ZERO;
                    end
                end else if ((burst_cnt >= C_BURST_MAX) && other_pick[2]) begin
                    owner_nxt = other_pick[1:0];
                    burst_nxt = C_ONE;
                end else if (burst_cnt < C_BURST_MAX) begin
                    burst_nxt = burst_cnt + C_ONE;
                end
            end
            default: begin
                // PARK and FORCE both resolve with the parking rules.
                if (any_pick[2]) begin
                    state_nxt = ST_OWN;
                    owner_nxt = any_pick[1:0];
                    burst_nxt = C_ONE;
                end else begin
                    state_nxt = ST_PARK;
                    burst_nxt = C_ZERO;
                end
            end
        endcase
        id_nxt = (state_nxt == ST_OWN) ? owner_nxt : 2'd1;
    end

    // Count consecutive cycles in which fetch requests but is not granted.
    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_o[1] || !req_i[1]) begin
            starve_nxt = C_ZERO;
        end else if (starve_cnt < C_STARVE_MAX) begin
            starve_nxt = starve_cnt + C_ONE;
        end
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_PARK;
            owner       <= 2'd0;
            burst_cnt   <= C_ZERO;
            starve_cnt  <= C_ZERO;
            grant_o     <= 4'b0010;
            gnt_id_o    <= 2'd1;
            hold_flag_o <= 1'b0;
            starve_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            burst_cnt   <= burst_nxt;
            starve_cnt  <= starve_nxt;
            grant_o     <= 4'b0001 << id_nxt;
            gnt_id_o    <= id_nxt;
            hold_flag_o <= (state_nxt == ST_OWN);
            starve_o    <= (state_nxt == ST_FORCE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rib_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rib_arbiter
// Purpose  : Self-checking bench for rib_arbiter with a cycle-level
//            ownership model and directed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_rib_arbiter;

    localparam int BL = 4;
    localparam int SL = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gnt_id;
    logic       hold_flag;
    logic       starve;

    int checks = 0;
    int errors = 0;

    // Model: who holds the bus (1 = fetch), how long, and fetch wait time.
    int m_cur   = 1;
    int m_run   = 0;
    int m_wait  = 0;
    bit m_force = 1'b0;
    bit m_valid = 1'b0;
    int gap     = 0;

    rib_arbiter #(
        .BURST_LIMIT (BL),
        .STARVE_LIMIT(SL),
        .CNT_W       (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .grant_o    (grant),
        .gnt_id_o   (gnt_id),
        .hold_flag_o(hold_flag),
        .starve_o   (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int best(input logic [3:0] r, input int excl);
        if (r[3] && excl != 3) return 3;
        if (r[2] && excl != 2) return 2;
        if (r[0] && excl != 0) return 0;
        return -1;
    endfunction

    // Behavioural model advanced on each rising edge.
    always @(posedge clk) begin : model
        int c;
        int r;
        int w;
        int h;
        bit f;
        bit starved;
        c = m_cur;
        r = m_run;
        w = m_wait;
        f = 1'b0;
        if (!rst) begin
            c = 1;
            r = 0;
            w = 0;
        end else begin
            starved = (c != 1) && req[1];
            w = starved ? ((w < SL) ? w + 1 : SL) : 0;
            if (starved && w >= SL) begin
                c = 1;
                r = 0;
                f = 1'b1;
            end else if (c == 1) begin
                h = best(req, -1);
                if (h >= 0) begin
                    c = h;
                    r = 1;
                end else begin
                    r = 0;
                end
            end else if (!req[c]) begin
                h = best(req, c);
                if (h >= 0) begin
                    c = h;
                    r = 1;
                end else begin
                    c = 1;
                    r = 0;
                end
            end else begin
                h = best(req, c);
                if (r >= BL && h >= 0) begin
                    c = h;
                    r = 1;
                end else if (r < BL) begin
                    r = r + 1;
                end
            end
        end
        m_cur   <= c;
        m_run   <= r;
        m_wait  <= w;
        m_force <= f;
        m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus structural invariants.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_grant", {28'd0, grant}, 32'(4'b0001 << m_cur));
            check("model_id", {30'd0, gnt_id}, 32'(m_cur));
            check("model_hold", {31'd0, hold_flag}, {31'd0, (m_cur != 1)});
            check("model_starve", {31'd0, starve}, {31'd0, m_force});
            check("onehot", {31'd0, $onehot(grant)}, 32'd1);
            check("id_match", {28'd0, grant}, 32'(4'b0001 << gnt_id));
            check("hold_inv", {31'd0, hold_flag}, {31'd0, ~grant[1]});
            if (req[1] && !grant[1]) gap++;
            else gap = 0;
            check("fetch_gap_ok", {31'd0, (gap <= SL)}, 32'd1);
        end
    end

    // Advance one edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_grant", {28'd0, grant}, 32'h2);
            check("idle_id", {30'd0, gnt_id}, 32'd1);
            check("idle_hold", {31'd0, hold_flag}, 32'd0);
        end

        // Priority and one-cycle latency.
        req = 4'b1101;
        tick();
        check("prio_m3", {28'd0, grant}, 32'h8);
        check("prio_hold", {31'd0, hold_flag}, 32'd1);
        req = 4'b0101;
        tick();
        check("release_m2", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        tick();
        check("park", {28'd0, grant}, 32'h2);

        // Burst rotation between m2 and m0.
        req = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("burst_rot", {28'd0, grant}, (((i / 4) % 2) == 0) ? 32'h4 : 32'h1);
        end
        req = 4'b0000;
        tick();
        check("burst_park", {28'd0, grant}, 32'h2);

        // Starvation: 8 cycles of m3 then one forced fetch cycle.
        req = 4'b1010;
        for (int i = 0; i < 18; i++) begin
            tick();
            check("starve_grant", {28'd0, grant}, ((i % 9) < 8) ? 32'h8 : 32'h2);
            check("starve_pulse", {31'd0, starve}, ((i % 9) == 8) ? 32'd1 : 32'd0);
        end
        req = 4'b0000;
        tick();

        // Reset in the middle of an m2 burst.
        req = 4'b0100;
        tick();
        tick();
        tick();
        check("pre_reset_m2", {28'd0, grant}, 32'h4);
        rst = 1'b0;
        tick();
        check("reset_grant", {28'd0, grant}, 32'h2);
        check("reset_starve", {31'd0, starve}, 32'd0);
        rst = 1'b1;
        tick();
        check("regrant_m2", {28'd0, grant}, 32'h4);
        req = 4'b0101;
        tick();
        check("post_reset_b2", {28'd0, grant}, 32'h4);
        tick();
        check("post_reset_b3", {28'd0, grant}, 32'h4);
        tick();
        check("post_reset_b4", {28'd0, grant}, 32'h4);
        tick();
        check("post_reset_switch", {28'd0, grant}, 32'h1);

        // Random traffic with occasional single-cycle resets.
        for (int i = 0; i < 10000; i++) begin
            req = 4'($urandom);
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
